// File: rtl/id_stage_module.sv
// Decode stage of the 5-stage pipeline.
// Takes pc+4 and the instruction from the fetch register and produces the
// ID/EX pipeline register. It contains the control unit, the condition check,
// a 16x32 register file written from WB, and the RAW hazard detector.
//
// Ports
//   clk, rst               clock and synchronous active-high reset
//   flush                  taken branch resolved in EX; squashes ID/EX
//   pc_in, instruction_in  inputs from the fetch register
//   status                 NZCV flags {N,Z,C,V}
//   wb_en/wb_dest/wb_value register file write port (from WB)
//   exe_*, mem_*           destinations in flight, used for hazard detection
//   hazard                 combinational freeze request to fetch
//   remaining outputs      registered ID/EX fields
module id_stage_module #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic [3:0]         status,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_dest,
  input  logic [DATA_W-1:0]  wb_value,
  input  logic               exe_wb_en,
  input  logic [REG_AW-1:0]  exe_dest,
  input  logic               mem_wb_en,
  input  logic [REG_AW-1:0]  mem_dest,
  output logic               hazard,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  val_rn,
  output logic [DATA_W-1:0]  val_rm,
  output logic [REG_AW-1:0]  dest,
  output logic [REG_AW-1:0]  src1,
  output logic [REG_AW-1:0]  src2,
  output logic [3:0]         exe_cmd,
  output logic               mem_r_en,
  output logic               mem_w_en,
  output logic               wb_en_out,
  output logic               b,
  output logic               s,
  output logic               imm,
  output logic [11:0]        shift_operand,
  output logic [23:0]        signed_imm_24
);

  localparam int NREG = 2 ** REG_AW;

  // Instruction fields
  logic [3:0]        cond;
  logic [1:0]        mode;
  logic              i_bit, s_bit;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] rn, rd, rm, src2_sel;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign i_bit  = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];
  assign rn     = instruction_in[16 +: REG_AW];
  assign rd     = instruction_in[12 +: REG_AW];
  assign rm     = instruction_in[0 +: REG_AW];

  // A store reads its data register (Rd) through the second read port.
  assign src2_sel = (mode == 2'b01 && !s_bit) ? rd : rm;

  // Register file
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] rd_rn, rd_src2;

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_dest] = wb_value;
  end

  // Write-through: a read of the register being written this cycle sees the
  // new value, so WB and ID need no extra forwarding path.
  assign rd_rn   = (wb_en && wb_dest == rn)       ? wb_value : regs_q[rn];
  assign rd_src2 = (wb_en && wb_dest == src2_sel) ? wb_value : regs_q[src2_sel];

  // Control unit
  logic [3:0] cmd_c;
  logic       wb_c, mr_c, mw_c, b_c, s_c;

  always_comb begin
    cmd_c = 4'b0000;
    wb_c  = 1'b0;
    mr_c  = 1'b0;
    mw_c  = 1'b0;
    b_c   = 1'b0;
    s_c   = 1'b0;
    unique case (mode)
      2'b00: begin
        wb_c = 1'b1;
        s_c  = s_bit;
        case (opcode)
          4'b1101: cmd_c = 4'b0001;  // MOV
          4'b1111: cmd_c = 4'b1001;  // MVN
          4'b0100: cmd_c = 4'b0010;  // ADD
          4'b0101: cmd_c = 4'b0011;  // ADC
          4'b0010: cmd_c = 4'b0100;  // SUB
          4'b0110: cmd_c = 4'b0101;  // SBC
          4'b0000: cmd_c = 4'b0110;  // AND
          4'b1100: cmd_c = 4'b0111;  // ORR
          4'b0001: cmd_c = 4'b1000;  // EOR
          4'b1010: begin cmd_c = 4'b0100; wb_c = 1'b0; end  // CMP
          4'b1000: begin cmd_c = 4'b0110; wb_c = 1'b0; end  // TST
          default: begin wb_c = 1'b0; s_c = 1'b0; end
        endcase
      end
      2'b01: begin
        cmd_c = 4'b0010;
        if (s_bit) begin mr_c = 1'b1; wb_c = 1'b1; end
        else       mw_c = 1'b1;
      end
      2'b10:   b_c = 1'b1;
      default: ;
    endcase
  end

  // Condition check on {N,Z,C,V}
  logic flag_n, flag_z, flag_c, flag_v, cond_pass;
  assign {flag_n, flag_z, flag_c, flag_v} = status;

  always_comb begin
    unique case (cond)
      4'h0:    cond_pass = flag_z;
      4'h1:    cond_pass = !flag_z;
      4'h2:    cond_pass = flag_c;
      4'h3:    cond_pass = !flag_c;
      4'h4:    cond_pass = flag_n;
      4'h5:    cond_pass = !flag_n;
      4'h6:    cond_pass = flag_v;
      4'h7:    cond_pass = !flag_v;
      4'h8:    cond_pass = flag_c && !flag_z;
      4'h9:    cond_pass = !flag_c || flag_z;
      4'hA:    cond_pass = (flag_n == flag_v);
      4'hB:    cond_pass = (flag_n != flag_v);
      4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
      4'hD:    cond_pass = flag_z || (flag_n != flag_v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Hazard detection
  logic rn_used, two_src;
  assign rn_used = !(opcode == 4'b1101 || opcode == 4'b1111 || mode == 2'b10);
  assign two_src = (mode == 2'b01 && !s_bit) || (mode == 2'b00 && !i_bit);
  assign hazard  = (rn_used && ((exe_wb_en && rn == exe_dest) ||
                                (mem_wb_en && rn == mem_dest))) ||
                   (two_src && ((exe_wb_en && src2_sel == exe_dest) ||
                                (mem_wb_en && src2_sel == mem_dest)));

  // ID/EX register
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              b;
    logic              s;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
  } id_ex_t;

  id_ex_t id_ex_d, id_ex_q;

  always_comb begin
    id_ex_d = '0;
    // A bubble clears every field, not only the controls, so a squashed
    // slot is indistinguishable from a flushed one downstream.
    if (!flush && !hazard) begin
      id_ex_d.pc            = pc_in;
      id_ex_d.val_rn        = rd_rn;
      id_ex_d.val_rm        = rd_src2;
      id_ex_d.dest          = rd;
      id_ex_d.src1          = rn;
      id_ex_d.src2          = src2_sel;
      id_ex_d.exe_cmd       = cmd_c;
      id_ex_d.mem_r_en      = mr_c && cond_pass;
      id_ex_d.mem_w_en      = mw_c && cond_pass;
      id_ex_d.wb_en         = wb_c && cond_pass;
      id_ex_d.b             = b_c && cond_pass;
      id_ex_d.s             = s_c && cond_pass;
      id_ex_d.imm           = i_bit;
      id_ex_d.shift_operand = instruction_in[11:0];
      id_ex_d.signed_imm_24 = instruction_in[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
      regs_q  <= '{default: '0};
    end else begin
      id_ex_q <= id_ex_d;
      regs_q  <= regs_d;
    end
  end

  assign pc            = id_ex_q.pc;
  assign val_rn        = id_ex_q.val_rn;
  assign val_rm        = id_ex_q.val_rm;
  assign dest          = id_ex_q.dest;
  assign src1          = id_ex_q.src1;
  assign src2          = id_ex_q.src2;
  assign exe_cmd       = id_ex_q.exe_cmd;
  assign mem_r_en      = id_ex_q.mem_r_en;
  assign mem_w_en      = id_ex_q.mem_w_en;
  assign wb_en_out     = id_ex_q.wb_en;
  assign b             = id_ex_q.b;
  assign s             = id_ex_q.s;
  assign imm           = id_ex_q.imm;
  assign shift_operand = id_ex_q.shift_operand;
  assign signed_imm_24 = id_ex_q.signed_imm_24;

endmodule

// File: tb/tb_id_stage_module.sv
// Directed bench for id_stage_module: expected ID/EX contents are queued when
// an instruction is presented and checked one cycle later.
module tb_id_stage_module;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] pc_in, instruction_in;
  logic [3:0]  status;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en, mem_wb_en;
  logic [3:0]  exe_dest, mem_dest;
  logic        hazard;
  logic [31:0] pc, val_rn, val_rm;
  logic [3:0]  dest, src1, src2, exe_cmd;
  logic        mem_r_en, mem_w_en, wb_en_out, b, s, imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  always #5 clk = ~clk;

  id_stage_module dut (
    .clk(clk), .rst(rst), .flush(flush), .pc_in(pc_in),
    .instruction_in(instruction_in), .status(status),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .hazard(hazard), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .dest(dest), .src1(src1), .src2(src2), .exe_cmd(exe_cmd),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_out(wb_en_out),
    .b(b), .s(s), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24)
  );

  typedef struct packed {
    logic [31:0] pc, vrn, vrm;
    logic [3:0]  dest, src1, src2, cmd;
    logic        mr, mw, wb, b, s, imm;
    logic [11:0] shop;
    logic [23:0] simm;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [31:0] NOP      = 32'hEC000000;  // mode 11: no controls
  localparam logic [31:0] ADD_R123 = 32'hE0821003;  // ADD R1,R2,R3
  localparam logic [31:0] ADD_R055 = 32'hE0850005;  // ADD R0,R5,R5
  localparam logic [31:0] MOV_R1_5 = 32'hE3A01005;  // MOV R1,#5
  localparam logic [31:0] ADDEQ    = 32'h00821003;
  localparam logic [31:0] ADDGT    = 32'hC0821003;
  localparam logic [31:0] ADDLT    = 32'hB0821003;
  localparam logic [31:0] CMP_R23  = 32'hE1520003;  // CMP R2,R3
  localparam logic [31:0] LDR      = 32'hE5921004;  // LDR R1,[R2,#4]
  localparam logic [31:0] STR      = 32'hE5821004;  // STR R1,[R2,#4]
  localparam logic [31:0] BR       = 32'hEA000010;
  localparam logic [31:0] RSC      = 32'hE0E21003;  // opcode 0111, not decoded

  function automatic exp_t mk(input logic [31:0] p, vrn, vrm, ins,
                              input logic [3:0] s2, cmd,
                              input logic mr, mw, wb, bb, ss);
    exp_t e;
    e.pc = p; e.vrn = vrn; e.vrm = vrm;
    e.dest = ins[15:12]; e.src1 = ins[19:16]; e.src2 = s2; e.cmd = cmd;
    e.mr = mr; e.mw = mw; e.wb = wb; e.b = bb; e.s = ss;
    e.imm = ins[25]; e.shop = ins[11:0]; e.simm = ins[23:0];
    return e;
  endfunction

  task automatic step(input string tag, input logic [31:0] p, ins,
                      input exp_t e, input logic exp_haz);
    exp_t obs, want;
    pc_in = p;
    instruction_in = ins;
    #1;
    n_assert++;
    assert (hazard === exp_haz) else begin
      n_fail++;
      $error("FAIL %s hazard: observed %b expected %b", tag, hazard, exp_haz);
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    rst = 0; flush = 0; wb_en = 0; exe_wb_en = 0; mem_wb_en = 0;
    obs = '{pc, val_rn, val_rm, dest, src1, src2, exe_cmd, mem_r_en, mem_w_en,
            wb_en_out, b, s, imm, shift_operand, signed_imm_24};
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s idex: observed output with empty scoreboard expected entry", tag);
    end else begin
      want = sb.pop_front();
      assert (obs === want) else begin
        n_fail++;
        $error("FAIL %s idex: observed %h expected %h", tag, obs, want);
      end
    end
  endtask

  task automatic wb(input logic [3:0] d, input logic [31:0] v);
    wb_en = 1; wb_dest = d; wb_value = v;
  endtask

  initial begin
    rst = 0; flush = 0; pc_in = 0; instruction_in = 0; status = 4'b0000;
    wb_en = 0; wb_dest = 0; wb_value = 0;
    exe_wb_en = 0; exe_dest = 0; mem_wb_en = 0; mem_dest = 0;
    @(negedge clk);

    rst = 1;
    step("reset", 32'h40, ADD_R123, '0, 1'b0);
    wb(4'd5, 32'h55);
    step("wr_r5", 32'h0, NOP, mk(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    rst = 1;
    step("reset2", 32'h0, NOP, '0, 1'b0);
    step("r5_cleared", 32'h8, ADD_R055,
         mk(32'h8, 0, 0, ADD_R055, 5, 4'b0010, 0, 0, 1, 0, 0), 1'b0);

    wb(4'd2, 32'd5);
    step("wr_r2", 32'h0, NOP, mk(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    wb(4'd3, 32'd7);
    step("wr_r3", 32'h0, NOP, mk(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step("add", 32'h104, ADD_R123,
         mk(32'h104, 5, 7, ADD_R123, 3, 4'b0010, 0, 0, 1, 0, 0), 1'b0);

    wb(4'd2, 32'hAA);
    step("bypass", 32'h108, ADD_R123,
         mk(32'h108, 32'hAA, 7, ADD_R123, 3, 4'b0010, 0, 0, 1, 0, 0), 1'b0);

    exe_wb_en = 1; exe_dest = 4'd2;
    step("raw_exe_rn", 32'h10C, ADD_R123, '0, 1'b1);
    mem_wb_en = 1; mem_dest = 4'd3;
    step("raw_mem_rm", 32'h10C, ADD_R123, '0, 1'b1);
    exe_wb_en = 1; exe_dest = 4'd0; mem_wb_en = 1; mem_dest = 4'd5;
    step("mov_no_haz", 32'h10C, MOV_R1_5,
         mk(32'h10C, 0, 0, MOV_R1_5, 5, 4'b0001, 0, 0, 1, 0, 0), 1'b0);

    status = 4'b0000;
    step("eq_fail", 32'h110, ADDEQ,
         mk(32'h110, 32'hAA, 7, ADDEQ, 3, 4'b0010, 0, 0, 0, 0, 0), 1'b0);
    status = 4'b0100;
    step("eq_pass", 32'h114, ADDEQ,
         mk(32'h114, 32'hAA, 7, ADDEQ, 3, 4'b0010, 0, 0, 1, 0, 0), 1'b0);
    status = 4'b1001;
    step("gt_pass", 32'h118, ADDGT,
         mk(32'h118, 32'hAA, 7, ADDGT, 3, 4'b0010, 0, 0, 1, 0, 0), 1'b0);
    step("lt_fail", 32'h11C, ADDLT,
         mk(32'h11C, 32'hAA, 7, ADDLT, 3, 4'b0010, 0, 0, 0, 0, 0), 1'b0);
    status = 4'b0000;

    step("cmp", 32'h120, CMP_R23,
         mk(32'h120, 32'hAA, 7, CMP_R23, 3, 4'b0100, 0, 0, 0, 0, 1), 1'b0);
    step("ldr", 32'h124, LDR,
         mk(32'h124, 32'hAA, 0, LDR, 4, 4'b0010, 1, 0, 1, 0, 0), 1'b0);
    wb(4'd1, 32'h11);
    step("str", 32'h128, STR,
         mk(32'h128, 32'hAA, 32'h11, STR, 1, 4'b0010, 0, 1, 0, 0, 0), 1'b0);

    flush = 1;
    step("flush_str", 32'h12C, STR, '0, 1'b0);
    flush = 1; exe_wb_en = 1; exe_dest = 4'd2;
    step("flush_haz", 32'h12C, ADD_R123, '0, 1'b1);

    exe_wb_en = 1; exe_dest = 4'd0;
    step("branch", 32'h130, BR,
         mk(32'h130, 0, 0, BR, 0, 4'b0000, 0, 0, 0, 1, 0), 1'b0);
    step("unlisted", 32'h134, RSC,
         mk(32'h134, 32'hAA, 7, RSC, 3, 4'b0000, 0, 0, 0, 0, 0), 1'b0);

    rst = 1;
    step("reset_mid", 32'h138, ADD_R123, '0, 1'b0);
    step("rf_cleared", 32'h200, ADD_R123,
         mk(32'h200, 0, 0, ADD_R123, 3, 4'b0010, 0, 0, 1, 0, 0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
